// File: rtl/linebuffer_pkg.sv
// Shared definitions for the line buffer draw-side controller.
//   LANES/LANE_W/WORD_W : 8 lanes of 9-bit pixels packed into one 72-bit word
//   BANK_AW             : word address width within one 256-word bank
//   lb_state_t          : draw sequencer states
//   lane_slice()        : extract one lane's pixel from a packed word
package linebuffer_pkg;

    localparam int unsigned LANES   = 8;
    localparam int unsigned LANE_W  = 9;
    localparam int unsigned WORD_W  = LANES * LANE_W;
    localparam int unsigned BANK_AW = 8;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DRAW,
        DONE
    } lb_state_t;

    function automatic logic [LANE_W-1:0] lane_slice(input logic [WORD_W-1:0] word,
                                                     input int unsigned       lane);
        return word[lane*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/linebuffer_if.sv
// Sprite drawer to controller beat bus.
//   draw_valid  : beat valid (master -> slave)
//   draw_ready  : controller accepts beat (slave -> master)
//   draw_addr   : word index within the back bank
//   draw_we     : per-lane write enables
//   draw_colour : 8 lanes x 9-bit pixel data
//   draw_done   : 1-cycle pulse, drawer finished this line
interface linebuffer_if;
    import linebuffer_pkg::*;

    logic                draw_valid;
    logic                draw_ready;
    logic [BANK_AW-1:0]  draw_addr;
    logic [LANES-1:0]    draw_we;
    logic [WORD_W-1:0]   draw_colour;
    logic                draw_done;

    modport master (
        output draw_valid,
        output draw_addr,
        output draw_we,
        output draw_colour,
        output draw_done,
        input  draw_ready
    );

    modport slave (
        input  draw_valid,
        input  draw_addr,
        input  draw_we,
        input  draw_colour,
        input  draw_done,
        output draw_ready
    );

endinterface

// File: rtl/linebuffer_wmux.sv
// Registered 2:1 write mux in front of the line buffer write port.
// Clear writes fill all lanes with CLEAR_COLOUR; draw writes pass the drawer's beat.
// Optional feature macro: LINEBUFFER_TRANSPARENCY_EN -- when defined, draw lanes whose
// pixel is 9'h000 are not written. Clear writes are never masked.
//   clk_draw, rst_draw_n : clock, synchronous active-low reset
//   clear_en, clear_addr : issue one clear write at {bank, word}
//   draw_en, draw_addr   : issue one draw write at {bank, word}
//   draw_we, draw_colour : lane enables and data for the draw write
//   bram_addr/we/colour  : registered write port, we=0 when nothing was issued
module linebuffer_wmux
    import linebuffer_pkg::*;
#(
    parameter logic [LANE_W-1:0] CLEAR_COLOUR = 9'h000
) (
    input  logic               clk_draw,
    input  logic               rst_draw_n,
    input  logic               clear_en,
    input  logic [BANK_AW:0]   clear_addr,
    input  logic               draw_en,
    input  logic [BANK_AW:0]   draw_addr,
    input  logic [LANES-1:0]   draw_we,
    input  logic [WORD_W-1:0]  draw_colour,
    output logic [BANK_AW:0]   bram_addr,
    output logic [LANES-1:0]   bram_we,
    output logic [WORD_W-1:0]  bram_colour
);

    logic [BANK_AW:0]  addr_q;
    logic [LANES-1:0]  we_q;
    logic [WORD_W-1:0] colour_q;
    logic [LANES-1:0]  lane_we;

    always_comb begin
        lane_we = draw_we;
`ifdef LINEBUFFER_TRANSPARENCY_EN
        // Colour 0 is transparent: leave the underlying pixel untouched.
        for (int i = 0; i < LANES; i++) begin
            lane_we[i] = draw_we[i] && (lane_slice(draw_colour, i) != '0);
        end
`endif
    end

    // Address and data hold their last value when idle; only the enables drop.
    always_ff @(posedge clk_draw) begin
        if (!rst_draw_n) begin
            addr_q   <= '0;
            we_q     <= '0;
            colour_q <= '0;
        end else if (clear_en) begin
            addr_q   <= clear_addr;
            we_q     <= '1;
            colour_q <= {LANES{CLEAR_COLOUR}};
        end else if (draw_en) begin
            addr_q   <= draw_addr;
            we_q     <= lane_we;
            colour_q <= draw_colour;
        end else begin
            we_q     <= '0;
        end
    end

    assign bram_addr   = addr_q;
    assign bram_we     = we_q;
    assign bram_colour = colour_q;

endmodule

// File: rtl/linebuffer_ctrl.sv
// Draw-side sequencer for the 512x72 ping-pong line buffer. The front bank (pix_bank) is
// scanned out; the back bank is cleared then drawn. Owns the buffer write port and shares
// it between the clear engine and the sprite drawer.
// Optional feature macro: LINEBUFFER_TRANSPARENCY_EN (see linebuffer_wmux).
//   clk_draw, rst_draw_n  : clock, synchronous active-low reset
//   line_start            : 1-cycle pulse, new scanline
//   draw                  : drawer beat bus (slave side)
//   bram_addr/we/colour   : line buffer write port
//   pix_bank              : current front bank
//   line_busy             : high in CLEAR or DRAW
//   overrun, overrun_clr  : sticky late-line flag and its clear
module linebuffer_ctrl
    import linebuffer_pkg::*;
#(
    parameter int unsigned       WORDS_PER_LINE = 256,
    parameter logic [LANE_W-1:0] CLEAR_COLOUR   = 9'h000
) (
    input  logic               clk_draw,
    input  logic               rst_draw_n,
    input  logic               line_start,
    linebuffer_if.slave        draw,
    output logic [BANK_AW:0]   bram_addr,
    output logic [LANES-1:0]   bram_we,
    output logic [WORD_W-1:0]  bram_colour,
    output logic               pix_bank,
    output logic               line_busy,
    output logic               overrun,
    input  logic               overrun_clr
);

    localparam logic [BANK_AW-1:0] LAST_WORD = BANK_AW'(WORDS_PER_LINE - 1);

    lb_state_t          state_q, state_d;
    logic [BANK_AW-1:0] cnt_q;
    logic               pix_bank_q;
    logic               overrun_q;
    logic               clear_en;
    logic               draw_ready_c;
    logic               accept;
    logic               in_range;
    logic               back_bank;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_draw) begin
        if (!rst_draw_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (line_start) begin
            state_d = CLEAR;
        end else begin
            case (state_q)
                CLEAR:   if (cnt_q == LAST_WORD) state_d = DRAW;
                DRAW:    if (draw.draw_done)     state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // A line_start cycle issues nothing: the banks flip on that edge, so any write
    // computed from the old back bank would land in the new front bank.
    always_comb begin
        draw_ready_c = (state_q == DRAW) && !line_start;
        clear_en     = (state_q == CLEAR) && !line_start;
        line_busy    = (state_q == CLEAR) || (state_q == DRAW);
    end

    assign draw.draw_ready = draw_ready_c;
    assign accept          = draw.draw_valid && draw_ready_c;
    assign in_range        = 32'(draw.draw_addr) < WORDS_PER_LINE;
    assign back_bank       = ~pix_bank_q;

    // Clear word counter
    always_ff @(posedge clk_draw) begin
        if (!rst_draw_n) begin
            cnt_q <= '0;
        end else if (line_start) begin
            cnt_q <= '0;
        end else if (state_q == CLEAR) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Bank flip and overrun flag; a late line_start beats overrun_clr.
    always_ff @(posedge clk_draw) begin
        if (!rst_draw_n) begin
            pix_bank_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (line_start) begin
                pix_bank_q <= ~pix_bank_q;
            end
            if (line_start && ((state_q == CLEAR) || (state_q == DRAW))) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign pix_bank = pix_bank_q;
    assign overrun  = overrun_q;

    // Out-of-range beats are accepted but write no lanes.
    linebuffer_wmux #(
        .CLEAR_COLOUR (CLEAR_COLOUR)
    ) u_wmux (
        .clk_draw    (clk_draw),
        .rst_draw_n  (rst_draw_n),
        .clear_en    (clear_en),
        .clear_addr  ({back_bank, cnt_q}),
        .draw_en     (accept),
        .draw_addr   ({back_bank, draw.draw_addr}),
        .draw_we     (in_range ? draw.draw_we : '0),
        .draw_colour (draw.draw_colour),
        .bram_addr   (bram_addr),
        .bram_we     (bram_we),
        .bram_colour (bram_colour)
    );

endmodule

// File: tb/tb_linebuffer_ctrl.sv
// Directed bench for linebuffer_ctrl: default instance (256 words) and a 160-word instance.
module tb_linebuffer_ctrl;

    logic clk_draw = 1'b0;
    always #5 clk_draw = ~clk_draw;

    // Default instance
    logic        rst_n, ls, oc;
    logic [8:0]  bram_addr;
    logic [7:0]  bram_we;
    logic [71:0] bram_colour;
    logic        pix_bank, line_busy, overrun;
    linebuffer_if lb_if ();

    linebuffer_ctrl dut (
        .clk_draw    (clk_draw),
        .rst_draw_n  (rst_n),
        .line_start  (ls),
        .draw        (lb_if),
        .bram_addr   (bram_addr),
        .bram_we     (bram_we),
        .bram_colour (bram_colour),
        .pix_bank    (pix_bank),
        .line_busy   (line_busy),
        .overrun     (overrun),
        .overrun_clr (oc)
    );

    // 160-word instance
    logic        rst160_n, ls160, oc160;
    logic [8:0]  addr160;
    logic [7:0]  we160;
    logic [71:0] colour160;
    logic        bank160, busy160, ovr160;
    linebuffer_if lb160_if ();

    linebuffer_ctrl #(
        .WORDS_PER_LINE (160)
    ) dut160 (
        .clk_draw    (clk_draw),
        .rst_draw_n  (rst160_n),
        .line_start  (ls160),
        .draw        (lb160_if),
        .bram_addr   (addr160),
        .bram_we     (we160),
        .bram_colour (colour160),
        .pix_bank    (bank160),
        .line_busy   (busy160),
        .overrun     (ovr160),
        .overrun_clr (oc160)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_draw);
        #1;
    endtask

    // Walk a clear sweep on one instance; optionally check draw_ready timing at the end.
    task automatic sweep(input int which, input int n, input logic [8:0] base,
                         input bit check_rdy, input string tag);
        int   bad      = 0;
        logic rdy_prev = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (which == 0) begin
                if (bram_we !== 8'hFF || bram_addr !== base + 9'(i) || bram_colour !== '0) bad++;
                if (i == n - 2) rdy_prev = lb_if.draw_ready;
            end else begin
                if (we160 !== 8'hFF || addr160 !== base + 9'(i) || colour160 !== '0) bad++;
                if (i == n - 2) rdy_prev = lb160_if.draw_ready;
            end
        end
        check_eq({tag, "_words"}, 72'(bad), 72'd0);
        if (check_rdy) begin
            check_eq({tag, "_rdy_early"}, 72'(rdy_prev), 72'd0);
            check_eq({tag, "_rdy"}, (which == 0) ? 72'(lb_if.draw_ready) : 72'(lb160_if.draw_ready),
                     72'd1);
        end
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] we, input logic [71:0] c,
                        input logic done);
        lb_if.draw_valid  = 1'b1;
        lb_if.draw_addr   = a;
        lb_if.draw_we     = we;
        lb_if.draw_colour = c;
        lb_if.draw_done   = done;
        tick();
        lb_if.draw_valid  = 1'b0;
        lb_if.draw_done   = 1'b0;
    endtask

    task automatic pulse_ls();
        ls = 1'b1;
        tick();
        ls = 1'b0;
    endtask

    logic [71:0] tcol;

    initial begin
        rst_n = 1'b0; ls = 1'b0; oc = 1'b0;
        lb_if.draw_valid = 1'b0; lb_if.draw_addr = '0; lb_if.draw_we = '0;
        lb_if.draw_colour = '0; lb_if.draw_done = 1'b0;
        rst160_n = 1'b0; ls160 = 1'b0; oc160 = 1'b0;
        lb160_if.draw_valid = 1'b0; lb160_if.draw_addr = '0; lb160_if.draw_we = '0;
        lb160_if.draw_colour = '0; lb160_if.draw_done = 1'b0;

        repeat (3) tick();
        check_eq("rst_bank",    72'(pix_bank), 72'd0);
        check_eq("rst_we",      72'(bram_we), 72'd0);
        check_eq("rst_addr",    72'(bram_addr), 72'd0);
        check_eq("rst_colour",  bram_colour, 72'd0);
        check_eq("rst_overrun", 72'(overrun), 72'd0);
        check_eq("rst_busy",    72'(line_busy), 72'd0);
        check_eq("rst_ready",   72'(lb_if.draw_ready), 72'd0);

        // Line 1: clear bank 0
        rst_n = 1'b1;
        tick();
        pulse_ls();
        check_eq("l1_bank", 72'(pix_bank), 72'd1);
        check_eq("l1_busy", 72'(line_busy), 72'd1);
        sweep(0, 256, 9'h000, 1'b1, "l1_clear");

        beat(8'h12, 8'h0F, 72'h1, 1'b0);
        check_eq("b1_we",     72'(bram_we), 72'h0F);
        check_eq("b1_addr",   72'(bram_addr), 72'h012);
        check_eq("b1_colour", bram_colour, 72'h1);
        tick();
        check_eq("idle_we",   72'(bram_we), 72'd0);
        check_eq("hold_addr", 72'(bram_addr), 72'h012);

        // Lanes 1 and 5 zero, others nonzero
        tcol = '0;
        for (int i = 0; i < 8; i++) begin
            if (i != 1 && i != 5) tcol[i*9 +: 9] = 9'(i + 1);
        end
        beat(8'h20, 8'hFF, tcol, 1'b0);
`ifdef LINEBUFFER_TRANSPARENCY_EN
        check_eq("transp_we", 72'(bram_we), 72'hDD);
`else
        check_eq("transp_we", 72'(bram_we), 72'hFF);
`endif

        // draw_done with a simultaneous beat
        check_eq("done_rdy_pre", 72'(lb_if.draw_ready), 72'd1);
        beat(8'h30, 8'h3C, 72'h5, 1'b1);
        check_eq("done_we",   72'(bram_we), 72'h3C);
        check_eq("done_addr", 72'(bram_addr), 72'h030);
        check_eq("done_rdy",  72'(lb_if.draw_ready), 72'd0);
        check_eq("done_busy", 72'(line_busy), 72'd0);
        beat(8'h31, 8'hFF, 72'h7, 1'b1);
        check_eq("done_nobeat", 72'(bram_we), 72'd0);

        // Line 2: from DONE, no overrun; line_start at clear count 100
        pulse_ls();
        check_eq("l2_bank",    72'(pix_bank), 72'd0);
        check_eq("l2_overrun", 72'(overrun), 72'd0);
        sweep(0, 100, 9'h100, 1'b0, "l2_part");
        ls = 1'b1;
        check_eq("ls_rdy", 72'(lb_if.draw_ready), 72'd0);
        tick();
        ls = 1'b0;
        check_eq("ovr_set",  72'(overrun), 72'd1);
        check_eq("ovr_bank", 72'(pix_bank), 72'd1);
        check_eq("ovr_gap",  72'(bram_we), 72'd0);
        sweep(0, 256, 9'h000, 1'b1, "l3_clear");

        oc = 1'b1;
        tick();
        oc = 1'b0;
        check_eq("ovr_clr", 72'(overrun), 72'd0);

        // Second overrun (from DRAW) with overrun_clr in the same cycle
        ls = 1'b1; oc = 1'b1;
        tick();
        ls = 1'b0; oc = 1'b0;
        check_eq("ovr_win",  72'(overrun), 72'd1);
        check_eq("l4_bank",  72'(pix_bank), 72'd0);
        sweep(0, 256, 9'h100, 1'b1, "l4_clear");
        beat(8'h12, 8'h0F, 72'h1, 1'b0);
        check_eq("b4_addr", 72'(bram_addr), 72'h112);
        check_eq("b4_we",   72'(bram_we), 72'h0F);

        // Reset mid-line with a beat in flight
        lb_if.draw_valid = 1'b1; lb_if.draw_addr = 8'h44; lb_if.draw_we = 8'hFF;
        rst_n = 1'b0;
        tick();
        lb_if.draw_valid = 1'b0;
        check_eq("mrst_we",   72'(bram_we), 72'd0);
        check_eq("mrst_busy", 72'(line_busy), 72'd0);
        check_eq("mrst_bank", 72'(pix_bank), 72'd0);
        check_eq("mrst_ovr",  72'(overrun), 72'd0);
        check_eq("mrst_rdy",  72'(lb_if.draw_ready), 72'd0);

        // 160-word instance
        rst160_n = 1'b1;
        tick();
        ls160 = 1'b1;
        tick();
        ls160 = 1'b0;
        sweep(1, 160, 9'h000, 1'b1, "w160_clear");
        lb160_if.draw_valid = 1'b1; lb160_if.draw_addr = 8'd200; lb160_if.draw_we = 8'hFF;
        lb160_if.draw_colour = 72'h3;
        check_eq("w160_oor_rdy", 72'(lb160_if.draw_ready), 72'd1);
        tick();
        check_eq("w160_oor_we", 72'(we160), 72'd0);
        lb160_if.draw_addr = 8'd159; lb160_if.draw_we = 8'h0F;
        tick();
        lb160_if.draw_valid = 1'b0;
        check_eq("w160_last_we",   72'(we160), 72'h0F);
        check_eq("w160_last_addr", 72'(addr160), 72'h09F);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
